dev_rx_packer: RTL
==================

Name: dev_rx_packer

Overview:
- Device-side receive stage directly upstream of the DMA controller.
- Accepts a peripheral byte stream and packs 4 bytes into little-endian 32-bit words.
- Buffers the words in a word FIFO and presents them on the DMA device interface (dev_data / dev_rdy / dev_rcv).
- Reports overflow and underflow on the DMA's error1 / error2 inputs.

Parameters:
- DEPTH, 8, word FIFO depth in 32-bit words; power of two, 2..64.
- AW, 3, FIFO pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- byte_valid  in  1  peripheral byte strobe; one byte per cycle while high.
- byte_data  in  8  peripheral byte.
- byte_ready  out  1  high when a byte presented this cycle will not be lost.
- flush  in  1  one-cycle pulse: push a partial word, zero-padded.
- dev_rdy  out  1  head word valid (FIFO not empty).
- dev_data  out  32  FIFO head word (first-word-fall-through); 0 when empty.
- dev_rcv  in  1  consumer acknowledge; one pop per rising edge of the level.
- error1  out  1  sticky overflow flag.
- error2  out  1  sticky underflow flag.
- clr_err  in  1  clears error1 and error2.
- word_count  out  AW+1  words currently held in the FIFO.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: FIFO empty, pointers 0, byte lane counter 0, shift word 0, dev_rcv_q 0. Outputs: dev_rdy=0, dev_data=0, error1=0, error2=0, word_count=0, byte_ready=1.
- Reset mid-operation discards all buffered words and any partial word.
- Packer:
  - 2-bit lane counter lc.
  - On byte_valid, byte_data goes to bits [8*lc+7 : 8*lc] of the shift word and lc increments, wrapping 3->0.
  - When the byte fills lane 3, the completed word (including this byte) is pushed the same cycle.
  - The first byte lands in [7:0].
- Push when full:
  - The word is dropped, error1 is set, lc returns to 0, and the shift word is cleared.
  - A simultaneous pop makes the FIFO not effectively full: the push is accepted and count is unchanged.
- byte_ready = ~(full & (lc==3)) & ~rst.
  - Combinational from registered state.
  - Ignores a same-cycle pop.
- flush:
  - If lc!=0 after including any same-cycle byte, push the shift word with unwritten upper lanes zero, then set lc=0.
  - If that byte itself completes a word, only that single push occurs.
  - If lc==0 and no byte completes, flush is a no-op.
  - Full-FIFO rules apply as for a normal push.
- Pop:
  - pop = dev_rcv & ~dev_rcv_q, with dev_rcv_q a registered copy. A held-high dev_rcv therefore pops exactly once.
  - The DMA holds dev_rcv across at least one rising edge.
  - Pop when empty: ignored, pointers unchanged, error2 set.
- Head word: dev_data = mem[rd_ptr] when !empty, else 0. dev_rdy = !empty.
  - A word pushed at edge N is visible on dev_data/dev_rdy after edge N (1-cycle latency).
  - A pop at edge N advances the head after edge N.
- Pointers: AW bits, wrap modulo DEPTH. word_count = wr_ptr - rd_ptr tracked as an AW+1 count.
  - full = (count==DEPTH), empty = (count==0).
- Errors:
  - Sticky until clr_err.
  - clr_err and a new error in the same cycle: the error wins (flag stays 1).

Decomposition:
- Package dev_rx_pkg holds:
  - BYTES_PER_WORD=4
  - LANE_W=2
  - function lane_insert(word, byte, lane)
- One sub-module, sync_fifo_fwft (params DEPTH, AW, W=32), with:
  - inputs: push, pop, din
  - outputs: dout, empty, full, count
- Packer, flush, pop edge-detect and error logic stay in dev_rx_packer.

Test Plan:
- Bytes 11,22,33,44 on 4 consecutive cycles -> dev_rdy rises the cycle after byte 44; dev_data=32'h44332211; word_count=1.
- Bytes AA,BB then flush pulse -> dev_data=32'h0000BBAA; lc back to 0. Next bytes 01..04 give 32'h04030201.
- Fill DEPTH=8 words, then push 4 more bytes without popping:
  - byte_ready=0 while lc==3.
  - 9th word dropped; error1=1; word_count stays 8.
  - clr_err -> error1=0.
- dev_rcv held high 5 cycles with 3 words queued -> exactly 1 pop; word_count 3->2; head advances one word.
- dev_rcv pulse while empty -> error2=1; pointers unchanged. Then push word 32'hDEADBEEF -> dev_data=32'hDEADBEEF.
- Full FIFO with a word-completing byte and a pop edge in the same cycle -> push accepted; word_count stays 8; error1 stays 0. Assert rst mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/dev_rx_pkg.sv
// dev_rx_pkg: shared constants and the byte-lane insert helper for the rx packer
package dev_rx_pkg;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W = 2;
    localparam int WORD_W = 8 * BYTES_PER_WORD;

    function automatic logic [WORD_W-1:0] lane_insert(
        input logic [WORD_W-1:0] w,
        input logic [7:0]        b,
        input logic [LANE_W-1:0] lane
    );
        logic [WORD_W-1:0] r;
        r = w;
        r[8*lane +: 8] = b;
        return r;
    endfunction
endpackage

// File: rtl/dev_rx_packer_if.sv
// dev_rx_packer_if: peripheral byte stream plus DMA device-side word interface
interface dev_rx_packer_if
    import dev_rx_pkg::*;
#(
    parameter int AW = 3
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              flush;
    logic              dev_rdy;
    logic [WORD_W-1:0] dev_data;
    logic              dev_rcv;
    logic              error1;
    logic              error2;
    logic              clr_err;
    logic [AW:0]       word_count;

    modport master (
        output byte_valid, byte_data, flush, dev_rcv, clr_err,
        input  byte_ready, dev_rdy, dev_data, error1, error2, word_count
    );

    modport slave (
        input  byte_valid, byte_data, flush, dev_rcv, clr_err,
        output byte_ready, dev_rdy, dev_data, error1, error2, word_count
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO; dout reads 0 while empty
module sync_fifo_fwft #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic [AW:0]  count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
    assign dout  = empty ? '0 : mem[rd_ptr];

    // storage write; callers only push with room (or with a same-cycle pop)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // pointers wrap naturally at DEPTH since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/dev_rx_packer.sv
// dev_rx_packer: packs bytes into little-endian words and queues them for the DMA
module dev_rx_packer
    import dev_rx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input logic             clk,
    input logic             rst,
    dev_rx_packer_if.slave  bus
);
    logic [LANE_W-1:0] lc, lc_nx;
    logic [WORD_W-1:0] sw, word_nx, head;
    logic              rcv_q, pop, pop_ok, push_req, push_ok, ovf, unf;
    logic              empty, full;
    logic [AW:0]       count;

    // pack the incoming byte, decide push/pop and classify error events
    always_comb begin
        word_nx  = bus.byte_valid ? lane_insert(sw, bus.byte_data, lc) : sw;
        lc_nx    = lc + LANE_W'(bus.byte_valid);
        push_req = (bus.byte_valid & (lc == LANE_W'(BYTES_PER_WORD - 1)))
                 | (bus.flush & (lc_nx != '0));
        pop      = bus.dev_rcv & ~rcv_q;
        pop_ok   = pop & ~empty;
        push_ok  = push_req & (~full | pop_ok);
        ovf      = push_req & ~push_ok;
        unf      = pop & empty;
    end

    // any push (accepted or dropped) restarts packing with a clean word so flush pads with zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            lc    <= '0;
            sw    <= '0;
            rcv_q <= 1'b0;
        end else begin
            lc    <= push_req ? '0 : lc_nx;
            sw    <= push_req ? '0 : word_nx;
            rcv_q <= bus.dev_rcv;
        end
    end

    // sticky error flags; a new event outranks a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.error1 <= 1'b0;
            bus.error2 <= 1'b0;
        end else begin
            bus.error1 <= ovf | (bus.error1 & ~bus.clr_err);
            bus.error2 <= unf | (bus.error2 & ~bus.clr_err);
        end
    end

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop_ok),
        .din   (word_nx),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign bus.byte_ready = ~(full & (lc == LANE_W'(BYTES_PER_WORD - 1))) & ~rst;
    assign bus.dev_rdy    = ~empty;
    assign bus.dev_data   = head;
    assign bus.word_count = count;
endmodule
